// File: rtl/gcbp_sync_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcbp_pkg (package)
// Description : Shared types and constants for the video line-count sync
//               detector: tracker state enumeration, count-step
//               classification and the default line-count width.
// Revision    : 1.0 - initial release
// ============================================================================
package gcbp_pkg;

    // Default width of the incoming line count
    localparam int c_CNT_W_DEFAULT = 10;

    // Tracker state
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_t;

    // Classification of a (previous, current) line-count pair
    typedef enum logic [2:0] {
        CLS_SAME     = 3'd0,
        CLS_STEP     = 3'd1,
        CLS_WRAP_OK  = 3'd2,
        CLS_WRAP_BAD = 3'd3,
        CLS_JUMP     = 3'd4
    } step_cls_t;

    // An illegal transition: forward jump by more than one, or wrap to nonzero
    function automatic logic cls_is_err(input step_cls_t cls);
        return (cls == CLS_WRAP_BAD) || (cls == CLS_JUMP);
    endfunction

    // Any backwards move of the count marks a frame boundary
    function automatic logic cls_is_wrap(input step_cls_t cls);
        return (cls == CLS_WRAP_OK) || (cls == CLS_WRAP_BAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcbp_sync_detect_cnt_step.sv
`default_nettype none
// ============================================================================
// Module      : gcbp_cnt_step
// Description : Combinational classifier of a line-count transition.
//               Ports:
//                 i_prev  - previously accepted line count
//                 i_cur   - newly presented line count
//                 o_cls   - SAME / STEP / WRAP_OK / WRAP_BAD / JUMP
// Revision    : 1.0 - initial release
// ============================================================================
module gcbp_cnt_step
    import gcbp_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic [CNT_W-1:0] i_prev,
    input  logic [CNT_W-1:0] i_cur,
    output step_cls_t        o_cls
);

    // One extra bit so that prev = all-ones increments to 2^CNT_W rather
    // than aliasing onto zero; a count can never legally step past the top.
    logic [CNT_W:0] w_prev_inc;

    assign w_prev_inc = {1'b0, i_prev} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        o_cls = CLS_SAME;
        if (i_cur == i_prev) begin
            o_cls = CLS_SAME;
        end else if (i_cur < i_prev) begin
            o_cls = (i_cur == '0) ? CLS_WRAP_OK : CLS_WRAP_BAD;
        end else if ({1'b0, i_cur} == w_prev_inc) begin
            o_cls = CLS_STEP;
        end else begin
            o_cls = CLS_JUMP;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcbp_sync_detect.sv
`default_nettype none
// ============================================================================
// Module      : gcbp_sync_detect
// Description : Watches the line count of a video timing source, pulses on
//               new lines / new frames / illegal count jumps, and declares
//               lock after LOCK_FRAMES consecutive clean frame wraps.
//               Ports:
//                 i_clk, i_resetn   - clock, synchronous active-low reset
//                 i_valid           - qualifies i_line_cnt
//                 i_line_cnt        - current line count
//                 o_new_line        - pulse: count changed
//                 o_new_frame       - pulse: count wrapped backwards
//                 o_skip_err        - pulse: illegal count transition
//                 o_locked          - level: timing stable
//                 o_frame_lines     - lines in last completed frame
//               Build option: define GCBP_SYNC_STATS_EN to enable the
//               frame-length statistics; otherwise o_frame_lines is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module gcbp_sync_detect
    import gcbp_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEFAULT,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] i_line_cnt,
    output logic             o_new_line,
    output logic             o_new_frame,
    output logic             o_skip_err,
    output logic             o_locked,
    output logic [CNT_W:0]   o_frame_lines
);

    localparam logic [4:0] c_LOCK_FRAMES = 5'(LOCK_FRAMES);

    sync_state_t      r_state;
    logic [CNT_W-1:0] r_prev;
    logic [3:0]       r_good;
    logic             r_new_line;
    logic             r_new_frame;
    logic             r_skip_err;
    logic             r_locked;

    step_cls_t        w_cls;
    logic             w_change;
    logic             w_wrap;
    logic             w_wrap_ok;
    logic             w_err;
    logic [4:0]       w_good_inc;
    logic [CNT_W:0]   w_frame_lines;

    gcbp_cnt_step #(
        .CNT_W (CNT_W)
    ) u_cnt_step (
        .i_prev (r_prev),
        .i_cur  (i_line_cnt),
        .o_cls  (w_cls)
    );

    assign w_change   = (w_cls != CLS_SAME);
    assign w_wrap     = cls_is_wrap(w_cls);
    assign w_wrap_ok  = (w_cls == CLS_WRAP_OK);
    assign w_err      = cls_is_err(w_cls);
    assign w_good_inc = {1'b0, r_good} + 5'd1;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state     <= ST_INIT;
            r_prev      <= '0;
            r_good      <= 4'd0;
            r_new_line  <= 1'b0;
            r_new_frame <= 1'b0;
            r_skip_err  <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_new_line  <= 1'b0;
            r_new_frame <= 1'b0;
            r_skip_err  <= 1'b0;
            // o_locked trails the state by one cycle, so lock/unlock becomes
            // visible the cycle after the wrap/error pulse that caused it.
            r_locked    <= (r_state == ST_LOCKED);

            if (i_valid) begin
                r_prev <= i_line_cnt;
                case (r_state)
                    ST_INIT: begin
                        // First sample only seeds the history; nothing to compare
                        r_state <= ST_SEARCH;
                    end
                    ST_SEARCH: begin
                        r_new_line  <= w_change;
                        r_new_frame <= w_wrap;
                        r_skip_err  <= w_err;
                        // Error is checked first so a bad wrap never counts
                        if (w_err) begin
                            r_good <= 4'd0;
                        end else if (w_wrap_ok) begin
                            if (w_good_inc >= c_LOCK_FRAMES) begin
                                r_state <= ST_LOCKED;
                                r_good  <= 4'd0;
                            end else begin
                                r_good <= w_good_inc[3:0];
                            end
                        end
                    end
                    ST_LOCKED: begin
                        r_new_line  <= w_change;
                        r_new_frame <= w_wrap;
                        r_skip_err  <= w_err;
                        if (w_err) begin
                            r_state <= ST_SEARCH;
                            r_good  <= 4'd0;
                        end
                    end
                    default: begin
                        r_state <= ST_INIT;
                    end
                endcase
            end
        end
    end

`ifdef GCBP_SYNC_STATS_EN
    logic [CNT_W:0] r_max_line;
    logic [CNT_W:0] r_frame_lines;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_max_line    <= '0;
            r_frame_lines <= '0;
        end else if (i_valid) begin
            // Highest line seen since the last frame boundary
            if ((r_state == ST_INIT) || w_wrap) begin
                r_max_line <= {1'b0, i_line_cnt};
            end else if ({1'b0, i_line_cnt} > r_max_line) begin
                r_max_line <= {1'b0, i_line_cnt};
            end
            // Only a clean wrap closes a frame; a bad wrap keeps the old value
            if ((r_state != ST_INIT) && w_wrap_ok) begin
                r_frame_lines <= {1'b0, r_prev} + {{CNT_W{1'b0}}, 1'b1};
            end
        end
    end

    assign w_frame_lines = r_frame_lines;
`else
    assign w_frame_lines = '0;
`endif

    assign o_new_line    = r_new_line;
    assign o_new_frame   = r_new_frame;
    assign o_skip_err    = r_skip_err;
    assign o_locked      = r_locked;
    assign o_frame_lines = w_frame_lines;

endmodule
`default_nettype wire

// File: tb/tb_gcbp_sync_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcbp_sync_detect
// Description : Scoreboard bench for gcbp_sync_detect. Each stimulus cycle
//               pushes the expected registered outputs (from a behavioural
//               model of the line-count rules) into a queue; a monitor pops
//               and compares them one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gcbp_sync_detect;

    localparam int CNT_W       = 10;
    localparam int LOCK_FRAMES = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

`ifdef GCBP_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             resetn;
    logic             valid;
    logic [CNT_W-1:0] line_cnt;
    logic             new_line;
    logic             new_frame;
    logic             skip_err;
    logic             locked;
    logic [CNT_W:0]   frame_lines;

    gcbp_sync_detect #(
        .CNT_W       (CNT_W),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_valid       (valid),
        .i_line_cnt    (line_cnt),
        .o_new_line    (new_line),
        .o_new_frame   (new_frame),
        .o_skip_err    (skip_err),
        .o_locked      (locked),
        .o_frame_lines (frame_lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit nl;
        bit nf;
        bit se;
        bit lk;
        int fl;
        int id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_issued = 0;

    // ---------------- behavioural reference model ----------------
    bit m_have;      // a reference count has been accepted since reset
    int m_prev;      // last accepted count
    int m_good;      // consecutive clean wraps while searching
    bit m_lock;      // tracker considers timing stable
    int m_fl;        // lines in last clean frame

    task automatic model_step(input bit r, input bit v, input int c);
        exp_t e;
        bool_t_dummy: begin end
        e.nl = 0; e.nf = 0; e.se = 0; e.lk = 0; e.fl = 0; e.id = n_issued;
        if (!r) begin
            m_have = 0; m_prev = 0; m_good = 0; m_lock = 0; m_fl = 0;
        end else begin
            e.lk = m_lock;   // lock level reflects the decision of the previous sample
            if (v) begin
                if (m_have) begin
                    bit going_back;
                    bit legal;
                    going_back = (c < m_prev);
                    legal      = (c == m_prev) || (c == m_prev + 1) || (going_back && c == 0);
                    e.nl = (c != m_prev);
                    e.nf = going_back;
                    e.se = !legal;
                    if (!legal) begin
                        m_good = 0;
                        m_lock = 0;
                    end else if (going_back) begin
                        m_fl = m_prev + 1;
                        if (!m_lock) begin
                            m_good++;
                            if (m_good >= LOCK_FRAMES) begin
                                m_lock = 1;
                                m_good = 0;
                            end
                        end
                    end
                end
                m_have = 1;
                m_prev = c;
            end
        end
        e.fl = STATS ? m_fl : 0;
        q.push_back(e);
        n_issued++;
    endtask

    task automatic drive(input bit r, input bit v, input int c);
        @(negedge clk);
        resetn   = r;
        valid    = v;
        line_cnt = CNT_W'(c);
        model_step(r, v, c);
    endtask

    // ---------------- monitor ----------------
    function automatic void chk(input string name, input int id, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, id, got, want);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("new_line",    e.id, int'(new_line),    int'(e.nl));
                chk("new_frame",   e.id, int'(new_frame),   int'(e.nf));
                chk("skip_err",    e.id, int'(skip_err),    int'(e.se));
                chk("locked",      e.id, int'(locked),      int'(e.lk));
                chk("frame_lines", e.id, int'(frame_lines), e.fl);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog time limit expired, pending=%0d expected=0", q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int cur;
        int flen;
        int sel;
        resetn   = 1'b0;
        valid    = 1'b0;
        line_cnt = '0;

        repeat (3) drive(0, 0, 0);

        // Three clean 525-line frames then the start of a fourth: lock after
        // the second clean wrap, frame length 525.
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < 525; l++)
                drive(1, 1, l);
        for (int l = 0; l <= 100; l++) drive(1, 1, l);
        // Forward skip while locked
        drive(1, 1, 103);
        drive(1, 1, 104);
        // Invalid cycles with a toggling count: nothing may change
        for (int i = 0; i < 20; i++) drive(1, 0, (i % 2) ? 1023 : 7);
        drive(1, 1, 105);
        drive(1, 1, 105);          // unchanged count
        // Top-of-range boundary: clean wrap then bad wrap
        drive(1, 1, 1023);
        drive(1, 1, 0);
        drive(1, 1, 1023);
        drive(1, 1, 5);
        // Get locked on short frames, reset mid-frame, then first sample
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < 10; l++)
                drive(1, 1, l);
        for (int l = 0; l < 5; l++) drive(1, 1, l);
        drive(0, 1, 6);
        drive(1, 1, 9);
        drive(1, 1, 10);

        // Randomized traffic
        cur  = 0;
        flen = 8;
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 1) begin
                drive(0, $urandom_range(0, 1), int'($urandom_range(0, CNT_MAX)));
            end else if (sel < 12) begin
                drive(1, 0, int'($urandom_range(0, CNT_MAX)));
            end else if (sel < 17) begin
                drive(1, 1, cur);
            end else if (sel < 20) begin
                cur = int'($urandom_range(0, CNT_MAX));
                drive(1, 1, cur);
            end else if (sel < 22) begin
                cur = 0;
                drive(1, 1, cur);
            end else begin
                if (cur + 1 >= flen || cur == CNT_MAX) begin
                    cur  = 0;
                    flen = int'($urandom_range(3, 20));
                end else begin
                    cur = cur + 1;
                end
                drive(1, 1, cur);
            end
        end

        drive(1, 0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drain", n_issued, q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
